// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int   c_data_width = 8;
    localparam logic c_par_even   = 1'b0;
    localparam logic c_par_odd    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_bit_counter.sv
// ============================================================================
// Module      : edge_bit_counter
// Description : Oversampling edge counter (0..prescale-1) and data-bit index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_bit_counter #(
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           prescale,
    input  logic                 en,
    input  logic                 bit_clr,
    input  logic                 bit_inc,
    output logic [4:0]           edge_cnt,
    output logic [IDX_WIDTH-1:0] bit_idx,
    output logic                 bit_end
);

    assign bit_end = (edge_cnt == (prescale - 5'd1));

    // Counter parks at zero while disabled so the first enabled cycle is edge 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= 5'd0;
        end else if (!en || bit_end) begin
            edge_cnt <= 5'd0;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (bit_clr) begin
            bit_idx <= '0;
        end else if (bit_inc) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive sequencer: start detect, deserialize, parity/stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [4:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int                   c_idx_width = $clog2(DATA_WIDTH);
    localparam logic [c_idx_width-1:0] c_last_idx = c_idx_width'(DATA_WIDTH - 1);

    rx_state_t              r_state;
    logic                   r_frame_bad;
    logic                   w_bit_end;
    logic [c_idx_width-1:0] w_bit_idx;
    logic                   w_cnt_en;
    logic                   w_bit_clr;
    logic                   w_bit_inc;

    assign w_cnt_en  = (r_state != ST_IDLE);
    assign w_bit_clr = (r_state == ST_START);
    assign w_bit_inc = (r_state == ST_DATA) && w_bit_end;

    edge_bit_counter #(
        .IDX_WIDTH (c_idx_width)
    ) u_edge_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .en       (w_cnt_en),
        .bit_clr  (w_bit_clr),
        .bit_inc  (w_bit_inc),
        .edge_cnt (edge_cnt),
        .bit_idx  (w_bit_idx),
        .bit_end  (w_bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_bad  <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            data_samp_en <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        r_state      <= ST_START;
                        r_frame_bad  <= 1'b0;
                        data_samp_en <= 1'b1;
                    end
                end
                ST_START: begin
                    // A start bit that does not vote low is treated as line noise.
                    if (w_bit_end) begin
                        if (!sampled_bit) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state      <= ST_IDLE;
                            data_samp_en <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        P_DATA[w_bit_idx] <= sampled_bit;
                        if (w_bit_idx == c_last_idx) begin
                            r_state <= PAR_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        if (sampled_bit != ((^P_DATA) ^ PAR_TYP)) begin
                            r_frame_bad <= 1'b1;
                            par_err     <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        stp_err    <= !sampled_bit;
                        data_valid <= sampled_bit && !r_frame_bad;
                        // Line already low here means the next start bit follows immediately.
                        if (!RX_IN) begin
                            r_state     <= ST_START;
                            r_frame_bad <= 1'b0;
                        end else begin
                            r_state      <= ST_IDLE;
                            data_samp_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    data_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_ctrl;

    localparam int c_max_cyc = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [4:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       data_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    int total = 0;
    int bad   = 0;

    // Per-cycle stimulus and expectations; cycle c is sampled by the c-th edge.
    logic line_q [c_max_cyc];
    logic samp_q [c_max_cyc];
    logic busy_q [c_max_cyc];
    int   ec_q   [c_max_cyc];

    int         exp_dv[$];
    logic [7:0] exp_dat[$];
    int         exp_pe[$];
    int         exp_se[$];
    int         obs_dv[$];
    logic [7:0] obs_dat[$];
    int         obs_pe[$];
    int         obs_se[$];
    logic [7:0] exp_pdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < c_max_cyc; i++) begin
            line_q[i] = 1'b1;
            samp_q[i] = 1'b1;
            busy_q[i] = 1'b0;
            ec_q[i]   = 0;
        end
        exp_dv.delete(); exp_dat.delete(); exp_pe.delete(); exp_se.delete();
        obs_dv.delete(); obs_dat.delete(); obs_pe.delete(); obs_se.delete();
    endtask

    task automatic cfg(input int p, input bit pe, input bit pt);
        prescale = 5'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
    endtask

    // Frame whose start bit appears on the line at cycle s; each bit lasts p cycles.
    task automatic add_frame(input int s, input int p, input bit pe, input bit pt,
                             input logic [7:0] data, input bit par_flip, input bit stop_v,
                             output int end_c);
        logic bits [11];
        int   nb;
        nb = 10 + int'(pe);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (pe) bits[9] = (^data) ^ pt ^ par_flip;
        bits[nb-1] = stop_v;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < p; j++) begin
                line_q[s + b*p + j]     = bits[b];
                samp_q[s + b*p + j + 1] = bits[b];
                busy_q[s + b*p + j]     = 1'b1;
                ec_q[s + b*p + j]       = j;
            end
        end
        if (pe && par_flip) exp_pe.push_back(s + p*(nb-1));
        if (!stop_v) exp_se.push_back(s + p*nb);
        if (stop_v && !(pe && par_flip)) begin
            exp_dv.push_back(s + p*nb);
            exp_dat.push_back(data);
        end
        exp_pdata = data;
        end_c = s + p*nb;
    endtask

    task automatic add_glitch(input int s, input int p, input int len);
        for (int j = 0; j < len; j++) line_q[s + j] = 1'b0;
        for (int j = 0; j < p; j++) begin
            busy_q[s + j] = 1'b1;
            ec_q[s + j]   = j;
        end
    endtask

    task automatic run_stream(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            RX_IN       = line_q[c];
            sampled_bit = samp_q[c];
            @(posedge clk);
            #1;
            chk($sformatf("samp_en@%0d", c), data_samp_en, busy_q[c]);
            chk($sformatf("edge_cnt@%0d", c), edge_cnt, ec_q[c]);
            if (data_valid === 1'b1) begin
                obs_dv.push_back(c);
                obs_dat.push_back(P_DATA);
            end
            if (par_err === 1'b1) obs_pe.push_back(c);
            if (stp_err === 1'b1) obs_se.push_back(c);
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_dv_count"}, obs_dv.size(), exp_dv.size());
        chk({tag, "_pe_count"}, obs_pe.size(), exp_pe.size());
        chk({tag, "_se_count"}, obs_se.size(), exp_se.size());
        for (int i = 0; i < exp_dv.size() && i < obs_dv.size(); i++) begin
            chk($sformatf("%s_dv_cycle%0d", tag, i), obs_dv[i], exp_dv[i]);
            chk($sformatf("%s_dv_data%0d", tag, i), obs_dat[i], exp_dat[i]);
        end
        for (int i = 0; i < exp_pe.size() && i < obs_pe.size(); i++)
            chk($sformatf("%s_pe_cycle%0d", tag, i), obs_pe[i], exp_pe[i]);
        for (int i = 0; i < exp_se.size() && i < obs_se.size(); i++)
            chk($sformatf("%s_se_cycle%0d", tag, i), obs_se[i], exp_se[i]);
        chk({tag, "_pdata"}, P_DATA, exp_pdata);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pdata"}, P_DATA, 0);
        chk({tag, "_dv"}, data_valid, 0);
        chk({tag, "_pe"}, par_err, 0);
        chk({tag, "_se"}, stp_err, 0);
        chk({tag, "_samp_en"}, data_samp_en, 0);
        chk({tag, "_edge_cnt"}, edge_cnt, 0);
    endtask

    initial begin
        int e1;
        int e2;
        int p;
        int g;
        int lat;
        bit pe;
        bit pt;

        rst = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
        cfg(8, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // 0xA5, prescale 8, no parity
        clear_model();
        add_frame(2, 8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, e1);
        run_stream(e1 + 12);
        check_events("a5");
        lat = (obs_dv.size() > 0) ? obs_dv[0] - 2 + 1 : -1;
        chk("a5_latency", lat, 81);

        // 0x3C, prescale 16, even parity: good, then corrupted parity bit
        cfg(16, 1'b1, 1'b0);
        clear_model();
        add_frame(2, 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, e1);
        run_stream(e1 + 20);
        check_events("3c_par_ok");
        lat = (obs_dv.size() > 0) ? obs_dv[0] - 2 + 1 : -1;
        chk("3c_latency", lat, 177);
        clear_model();
        add_frame(2, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, e1);
        run_stream(e1 + 20);
        check_events("3c_par_bad");

        // Short low glitch: no pulses, P_DATA retained
        cfg(8, 1'b0, 1'b0);
        clear_model();
        add_glitch(2, 8, 3);
        run_stream(30);
        check_events("glitch");

        // Bad stop bit
        clear_model();
        add_frame(2, 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, e1);
        run_stream(e1 + 12);
        check_events("stop_bad");

        // Back-to-back frames with no idle gap
        clear_model();
        add_frame(2, 8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, e1);
        add_frame(e1, 8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, e2);
        run_stream(e2 + 12);
        check_events("b2b");
        lat = (obs_dv.size() > 1) ? obs_dv[1] - obs_dv[0] : -1;
        chk("b2b_spacing", lat, 80);

        // Reset in the middle of data bit 4, then a clean frame
        clear_model();
        add_frame(2, 8, 1'b0, 1'b0, 8'h6B, 1'b0, 1'b1, e1);
        run_stream(2 + 5*8 + 4);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_pdata = 8'h00;
        clear_model();
        add_frame(2, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, e1);
        run_stream(e1 + 12);
        check_events("after_rst");

        // Randomized frames, optionally back-to-back or with idle gap
        for (int r = 0; r < 10; r++) begin
            p  = 2 * $urandom_range(3, 15);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            cfg(p, pe, pt);
            clear_model();
            add_frame(2, p, pe, pt, 8'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0), e1);
            e2 = e1;
            if ($urandom_range(0, 1) == 1) begin
                g = $urandom_range(0, 2);
                add_frame(e1 + g*p, p, pe, pt, 8'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) != 0), e2);
            end
            run_stream(e2 + p + 4);
            check_events($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
